// File: rtl/waterbear_pkg.sv
// ---------------------------------------------------------------------------
// waterbear_pkg
//
// Purpose : shared definitions for the waterbear accumulator core.
//           Holds the opcode width, the opcode encoding and the
//           encoding of the core's control states.
//
// Contents:
//   OPCODE_W  - width of the opcode field in an instruction word
//   opcode_e  - architectural opcodes 0..8; encodings 9..15 are illegal
//   state_e   - control states IDLE, IF, ID, EX, WB, HALT
// ---------------------------------------------------------------------------
package waterbear_pkg;

   localparam int OPCODE_W = 4;

   typedef enum logic [OPCODE_W-1:0] {
      OP_NOP = 4'd0,
      OP_LDR = 4'd1,
      OP_STR = 4'd2,
      OP_ADD = 4'd3,
      OP_SUB = 4'd4,
      OP_EQU = 4'd5,
      OP_JMP = 4'd6,
      OP_HLT = 4'd7,
      OP_JNZ = 4'd8
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EX   = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_e;

endpackage

// File: rtl/waterbear_alu.sv
// ---------------------------------------------------------------------------
// waterbear_alu
//
// Purpose : combinational arithmetic/compare block of the waterbear core.
//           Adds or subtracts two DATA_W-bit words and compares them.
//
// Parameters:
//   DATA_W  - operand and result width
//
// Ports:
//   a       in   DATA_W  accumulator side operand
//   b       in   DATA_W  operand value (immediate or memory word)
//   sub     in   1       1 = a - b, 0 = a + b
//   result  out  DATA_W  sum or difference, modulo 2^DATA_W
//   carry   out  1       carry out of the add, or borrow out of the subtract
//   eq      out  1       a == b
// ---------------------------------------------------------------------------
module waterbear_alu
   import waterbear_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              eq
);

   logic [DATA_W:0] ext;

   // One extra bit holds the carry; for a subtract it goes high exactly
   // when b > a, i.e. on a borrow.
   always_comb begin
      if (sub) begin
         ext = {1'b0, a} - {1'b0, b};
      end else begin
         ext = {1'b0, a} + {1'b0, b};
      end
   end

   assign result = ext[DATA_W-1:0];
   assign carry  = ext[DATA_W];
   assign eq     = (a == b);

endmodule

// File: rtl/waterbear_pcore.sv
// ---------------------------------------------------------------------------
// waterbear_pcore
//
// Purpose : single-accumulator CPU core with private instruction and data
//           memories, a host program-load port and a run/halt handshake.
//           Every instruction walks IF -> ID -> EX -> WB; HLT and illegal
//           opcodes leave from EX straight to HALT.
//
// Parameters:
//   DATA_W      - accumulator / data-memory word width
//   ADDR_W      - PC and operand width; IMEM depth is 2^ADDR_W
//   DMEM_DEPTH  - data-memory words (at most 2^ADDR_W)
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous reset, active low
//   run        in   1          start pulse, honoured in IDLE/HALT only
//   prog_we    in   1          IMEM write strobe, honoured in IDLE/HALT only
//   prog_addr  in   ADDR_W     IMEM write address
//   prog_data  in   5+ADDR_W   instruction {opcode[3:0], numbit, operand}
//   dbg_addr   in   ADDR_W     DMEM debug read address
//   dbg_data   out  DATA_W     DMEM[dbg_addr], 0 when out of range
//   pc         out  ADDR_W     program counter
//   acc        out  DATA_W     accumulator
//   carry      out  1          carry/borrow of the last ADD/SUB
//   busy       out  1          core is in IF/ID/EX/WB
//   halted     out  1          core is in HALT
//   err        out  1          illegal opcode seen (sticky until reset/run)
//   instr_cnt  out  32         retired-instruction count
//
// Build option:
//   WATERBEAR_INSTR_CNT_EN  - when defined, instr_cnt is a live 32-bit
//                             counter of instructions retired at WB;
//                             otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module waterbear_pcore
   import waterbear_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int DMEM_DEPTH = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       prog_we,
   input  logic [ADDR_W-1:0]          prog_addr,
   input  logic [OPCODE_W+ADDR_W:0]   prog_data,
   input  logic [ADDR_W-1:0]          dbg_addr,
   output logic [DATA_W-1:0]          dbg_data,
   output logic [ADDR_W-1:0]          pc,
   output logic [DATA_W-1:0]          acc,
   output logic                       carry,
   output logic                       busy,
   output logic                       halted,
   output logic                       err,
   output logic [31:0]                instr_cnt
);

   localparam int INSTR_W    = OPCODE_W + 1 + ADDR_W;
   localparam int IMEM_DEPTH = 1 << ADDR_W;
   localparam int DMEM_AW    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
   localparam logic [ADDR_W:0] DMEM_LIMIT = (ADDR_W+1)'(DMEM_DEPTH);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [INSTR_W-1:0] imem [IMEM_DEPTH];
   logic [DATA_W-1:0]  dmem [DMEM_DEPTH];

   state_e             state;
   logic [INSTR_W-1:0] cir;
   logic [ADDR_W-1:0]  pc_q;
   logic [DATA_W-1:0]  acc_q;
   logic               carry_q;
   logic               err_q;

   // ------------------------------------------------------------------
   // Decode of the current instruction register
   // ------------------------------------------------------------------
   opcode_e            opcode;
   logic               numbit;
   logic [ADDR_W-1:0]  operand;
   logic [DATA_W-1:0]  imm;
   logic [DATA_W-1:0]  dmem_rd;
   logic [DATA_W-1:0]  opnd_val;
   logic               opnd_in_range;
   logic               dbg_in_range;
   logic               host_phase;
   logic               str_commit;

   logic [DATA_W-1:0]  alu_result;
   logic               alu_carry;
   logic               alu_eq;

   assign opcode  = opcode_e'(cir[INSTR_W-1 -: OPCODE_W]);
   assign numbit  = cir[ADDR_W];
   assign operand = cir[ADDR_W-1:0];

   // The size cast zero-extends when DATA_W > ADDR_W and truncates when
   // DATA_W < ADDR_W, so one expression covers every parameter choice.
   assign imm = DATA_W'(operand);

   // Addresses past the end of DMEM read as zero and are never written.
   assign opnd_in_range = ({1'b0, operand}  < DMEM_LIMIT);
   assign dbg_in_range  = ({1'b0, dbg_addr} < DMEM_LIMIT);

   assign dmem_rd  = opnd_in_range ? dmem[operand[DMEM_AW-1:0]] : '0;
   assign opnd_val = numbit ? imm : dmem_rd;
   assign dbg_data = dbg_in_range ? dmem[dbg_addr[DMEM_AW-1:0]] : '0;

   // The host owns the core only while it is parked.
   assign host_phase = (state == ST_IDLE) || (state == ST_HALT);

   waterbear_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (acc_q),
      .b      (opnd_val),
      .sub    (opcode == OP_SUB),
      .result (alu_result),
      .carry  (alu_carry),
      .eq     (alu_eq)
   );

   // ------------------------------------------------------------------
   // Instruction memory: host load port. A write presented together with
   // run lands on the same edge the core leaves IDLE/HALT, so the first
   // fetch one cycle later already sees it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (prog_we && host_phase) begin
         imem[prog_addr] <= prog_data;
      end
   end

   // ------------------------------------------------------------------
   // Data memory: STR commits on the edge that ends EX. The rst term keeps
   // a store from landing on an edge where reset is being held.
   // ------------------------------------------------------------------
   assign str_commit = rst && (state == ST_EX) && (opcode == OP_STR) &&
                       opnd_in_range;

   always_ff @(posedge clk) begin
      if (str_commit) begin
         dmem[operand[DMEM_AW-1:0]] <= acc_q;
      end
   end

   // ------------------------------------------------------------------
   // Control FSM, PC, accumulator and flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         cir     <= '0;
         pc_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               // acc survives a restart so a program can continue from
               // the previous result.
               if (run) begin
                  pc_q    <= '0;
                  carry_q <= 1'b0;
                  err_q   <= 1'b0;
                  state   <= ST_IF;
               end
            end
            ST_IF: begin
               cir   <= imem[pc_q];
               pc_q  <= pc_q + ADDR_W'(1);
               state <= ST_ID;
            end
            ST_ID: begin
               state <= ST_EX;
            end
            ST_EX: begin
               state <= ST_WB;
               case (opcode)
                  OP_NOP: ;
                  OP_LDR: acc_q <= opnd_val;
                  OP_STR: ;
                  OP_ADD, OP_SUB: begin
                     acc_q   <= alu_result;
                     carry_q <= alu_carry;
                  end
                  OP_EQU: begin
                     // pc already points past EQU; one more skips the next.
                     if (alu_eq) begin
                        pc_q <= pc_q + ADDR_W'(1);
                     end
                  end
                  OP_JMP: pc_q <= operand;
                  OP_HLT: state <= ST_HALT;
                  OP_JNZ: begin
                     if (acc_q != '0) begin
                        pc_q <= operand;
                     end
                  end
                  default: begin
                     err_q <= 1'b1;
                     state <= ST_HALT;
                  end
               endcase
            end
            ST_WB: begin
               state <= ST_IF;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Retired-instruction counter
   // ------------------------------------------------------------------
`ifdef WATERBEAR_INSTR_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (host_phase && run) begin
         cnt_q <= '0;
      end else if (state == ST_WB) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign instr_cnt = cnt_q;
`else
   assign instr_cnt = '0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pc     = pc_q;
   assign acc    = acc_q;
   assign carry  = carry_q;
   assign err    = err_q;
   assign halted = (state == ST_HALT);
   assign busy   = (state == ST_IF) || (state == ST_ID) ||
                   (state == ST_EX) || (state == ST_WB);

endmodule

// File: tb/tb_waterbear_pcore.sv
// ---------------------------------------------------------------------------
// tb_waterbear_pcore
//
// Directed programs are loaded through the host port and started with run.
// For each program the hand-computed end state is pushed into a scoreboard
// queue; an independent monitor pops an entry every time halted rises and
// compares the architectural outputs against it. Timing-sensitive checks
// (reset, mid-instruction reset, handshake latency) are done inline.
// ---------------------------------------------------------------------------
module tb_waterbear_pcore;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 8;
   localparam int DMEM_DEPTH = 128;

`ifdef WATERBEAR_INSTR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDR = 4'd1;
   localparam logic [3:0] OP_STR = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_EQU = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_HLT = 4'd7;
   localparam logic [3:0] OP_JNZ = 4'd8;
   localparam logic [3:0] OP_BAD = 4'd12;

   logic                clk       = 1'b0;
   logic                rst       = 1'b0;
   logic                run       = 1'b0;
   logic                prog_we   = 1'b0;
   logic [ADDR_W-1:0]   prog_addr = '0;
   logic [ADDR_W+4:0]   prog_data = '0;
   logic [ADDR_W-1:0]   dbg_addr  = '0;
   logic [DATA_W-1:0]   dbg_data;
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W-1:0]   acc;
   logic                carry;
   logic                busy;
   logic                halted;
   logic                err;
   logic [31:0]         instr_cnt;

   typedef struct {
      int          id;
      logic [7:0]  acc;
      logic        carry;
      logic        err;
      logic [7:0]  pc;
      logic [31:0] cnt;
      logic [7:0]  dbg;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   waterbear_pcore #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DMEM_DEPTH (DMEM_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .pc         (pc),
      .acc        (acc),
      .carry      (carry),
      .busy       (busy),
      .halted     (halted),
      .err        (err),
      .instr_cnt  (instr_cnt)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Backstop in case the core or the bench wedges somewhere unexpected.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and reports it when it does not match.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
      end
   endtask

   // Build an instruction word {opcode, numbit, operand}.
   function automatic logic [ADDR_W+4:0] enc(input logic [3:0] op, input logic nb,
                                             input logic [7:0] opnd);
      return {op, nb, opnd};
   endfunction

   // Queue the hand-computed end state of the program about to run.
   task automatic pushExp(input int id, input logic [7:0] eAcc, input logic eCarry,
                          input logic eErr, input logic [7:0] ePc, input int eCnt,
                          input logic [7:0] eDbg);
      exp_t e;
      e.id    = id;
      e.acc   = eAcc;
      e.carry = eCarry;
      e.err   = eErr;
      e.pc    = ePc;
      e.cnt   = CNT_EN ? 32'(eCnt) : 32'd0;
      e.dbg   = eDbg;
      sbq.push_back(e);
   endtask

   // Write one IMEM word through the host port (one clock).
   task automatic loadWord(input logic [7:0] a, input logic [ADDR_W+4:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      @(posedge clk); #1;
      prog_we   = 1'b0;
   endtask

   // Wait, with a cycle budget, for halted; cyc counts edges after run.
   task automatic waitHalt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("halt_reached", 32'(halted), 32'd1);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   // Pulse run for one cycle, check the start handshake, then wait for halt.
   task automatic applyStimulus(output int cyc);
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      checkOutput("busy_after_run", 32'(busy), 32'd1);
      checkOutput("err_clear_on_run", 32'(err), 32'd0);
      checkOutput("pc_clear_on_run", 32'(pc), 32'd0);
      waitHalt(cyc);
   endtask

   // Scoreboard monitor: every rising edge of halted consumes one expected
   // end state and compares all architectural outputs against it.
   initial begin : monitor
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (halted && !prev) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_halt: got halt at pc %0d required none", pc);
            end else begin
               e = sbq.pop_front();
               checkOutput($sformatf("p%0d_acc", e.id),   32'(acc),   32'(e.acc));
               checkOutput($sformatf("p%0d_carry", e.id), 32'(carry), 32'(e.carry));
               checkOutput($sformatf("p%0d_err", e.id),   32'(err),   32'(e.err));
               checkOutput($sformatf("p%0d_pc", e.id),    32'(pc),    32'(e.pc));
               checkOutput($sformatf("p%0d_cnt", e.id),   instr_cnt,  e.cnt);
               checkOutput($sformatf("p%0d_dbg", e.id),   32'(dbg_data), 32'(e.dbg));
               checkOutput($sformatf("p%0d_busy", e.id),  32'(busy),  32'd0);
            end
         end
         prev = halted;
      end
   end

   // Directed program sequence.
   initial begin : stimulus
      int cyc;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_acc", 32'(acc), 32'd0);
      checkOutput("rst_carry", 32'(carry), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_cnt", instr_cnt, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // P1: counting loop; EQU against DMEM[15]=5 eventually skips to HLT.
      loadWord(0, enc(OP_LDR, 1'b1, 8'd5));
      loadWord(1, enc(OP_STR, 1'b0, 8'd15));
      loadWord(2, enc(OP_LDR, 1'b1, 8'd0));
      loadWord(3, enc(OP_EQU, 1'b0, 8'd15));
      loadWord(4, enc(OP_JMP, 1'b1, 8'd6));
      loadWord(5, enc(OP_HLT, 1'b0, 8'd0));
      loadWord(6, enc(OP_ADD, 1'b1, 8'd1));
      loadWord(7, enc(OP_JMP, 1'b1, 8'd3));
      dbg_addr = 8'd15;
      pushExp(1, 8'd5, 1'b0, 1'b0, 8'd6, 24, 8'd5);
      applyStimulus(cyc);
      checkOutput("p1_cycles", 32'(cyc), 32'd99);

      // P2a: 200 + DMEM[30](=100) = 300 -> 44 with carry.
      loadWord(0, enc(OP_LDR, 1'b1, 8'd100));
      loadWord(1, enc(OP_STR, 1'b0, 8'd30));
      loadWord(2, enc(OP_LDR, 1'b1, 8'd200));
      loadWord(3, enc(OP_ADD, 1'b0, 8'd30));
      loadWord(4, enc(OP_HLT, 1'b0, 8'd0));
      dbg_addr = 8'd30;
      pushExp(2, 8'd44, 1'b1, 1'b0, 8'd5, 4, 8'd100);
      applyStimulus(cyc);

      // P2b: acc persists across run; 44 - 50 borrows -> 250, carry 1.
      loadWord(0, enc(OP_SUB, 1'b1, 8'd50));
      loadWord(1, enc(OP_HLT, 1'b0, 8'd0));
      pushExp(3, 8'd250, 1'b1, 1'b0, 8'd2, 1, 8'd100);
      applyStimulus(cyc);

      // P3: illegal opcode 12 halts with err three cycles after busy rises.
      loadWord(0, enc(OP_BAD, 1'b0, 8'd0));
      dbg_addr = 8'd15;
      pushExp(4, 8'd250, 1'b0, 1'b1, 8'd1, 0, 8'd5);
      applyStimulus(cyc);
      checkOutput("p4_illegal_latency", 32'(cyc), 32'd3);

      // P3b: the next run clears err.
      loadWord(0, enc(OP_HLT, 1'b0, 8'd0));
      pushExp(5, 8'd250, 1'b0, 1'b0, 8'd1, 0, 8'd5);
      applyStimulus(cyc);
      checkOutput("p5_hlt_latency", 32'(cyc), 32'd3);

      // P4: JNZ loop counting 3 down to 0.
      loadWord(0, enc(OP_LDR, 1'b1, 8'd3));
      loadWord(1, enc(OP_SUB, 1'b1, 8'd1));
      loadWord(2, enc(OP_JNZ, 1'b1, 8'd1));
      loadWord(3, enc(OP_HLT, 1'b0, 8'd0));
      pushExp(6, 8'd0, 1'b0, 1'b0, 8'd4, 7, 8'd5);
      applyStimulus(cyc);

      // P5 setup: DMEM[20] <- 77.
      loadWord(0, enc(OP_LDR, 1'b1, 8'd77));
      loadWord(1, enc(OP_STR, 1'b0, 8'd20));
      loadWord(2, enc(OP_HLT, 1'b0, 8'd0));
      dbg_addr = 8'd20;
      pushExp(7, 8'd77, 1'b0, 1'b0, 8'd3, 2, 8'd77);
      applyStimulus(cyc);

      // P5: reset during the EX of STR 20 must not let 99 reach DMEM[20].
      loadWord(0, enc(OP_LDR, 1'b1, 8'd99));
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      checkOutput("p8_pre_reset_acc", 32'(acc), 32'd99);
      rst = 1'b0;
      #1;
      checkOutput("p8_reset_pc", 32'(pc), 32'd0);
      checkOutput("p8_reset_busy", 32'(busy), 32'd0);
      checkOutput("p8_reset_halted", 32'(halted), 32'd0);
      checkOutput("p8_reset_acc", 32'(acc), 32'd0);
      checkOutput("p8_reset_dmem", 32'(dbg_data), 32'd77);
      @(posedge clk); #1;
      checkOutput("p8_reset_dmem_edge", 32'(dbg_data), 32'd77);
      rst = 1'b1;
      @(posedge clk); #1;

      // P6: host writes while busy are ignored; a rerun gives the same result.
      loadWord(0, enc(OP_LDR, 1'b1, 8'd5));
      loadWord(1, enc(OP_ADD, 1'b1, 8'd7));
      loadWord(2, enc(OP_HLT, 1'b0, 8'd0));
      pushExp(9, 8'd12, 1'b0, 1'b0, 8'd3, 2, 8'd77);
      run = 1'b1;
      @(posedge clk); #1;
      run       = 1'b0;
      prog_we   = 1'b1;
      prog_addr = 8'd1;
      prog_data = enc(OP_ADD, 1'b1, 8'd100);
      repeat (4) begin
         checkOutput("p9_busy_during_write", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      prog_we = 1'b0;
      waitHalt(cyc);
      pushExp(10, 8'd12, 1'b0, 1'b0, 8'd3, 2, 8'd77);
      applyStimulus(cyc);

      // P7: prog_we and run in the same cycle -- the write lands first.
      loadWord(1, enc(OP_HLT, 1'b0, 8'd0));
      pushExp(11, 8'd42, 1'b0, 1'b0, 8'd2, 1, 8'd77);
      prog_we   = 1'b1;
      prog_addr = 8'd0;
      prog_data = enc(OP_LDR, 1'b1, 8'd42);
      run       = 1'b1;
      @(posedge clk); #1;
      prog_we = 1'b0;
      run     = 1'b0;
      checkOutput("p11_busy_after_run", 32'(busy), 32'd1);
      waitHalt(cyc);

      // P8: out-of-range DMEM reads give 0 and writes are dropped;
      // LDR right after STR to the same address sees the stored value.
      loadWord(0, enc(OP_LDR, 1'b1, 8'd9));
      loadWord(1, enc(OP_STR, 1'b0, 8'd200));
      loadWord(2, enc(OP_LDR, 1'b0, 8'd200));
      loadWord(3, enc(OP_ADD, 1'b1, 8'd6));
      loadWord(4, enc(OP_STR, 1'b0, 8'd40));
      loadWord(5, enc(OP_LDR, 1'b0, 8'd40));
      loadWord(6, enc(OP_HLT, 1'b0, 8'd0));
      dbg_addr = 8'd40;
      pushExp(12, 8'd6, 1'b0, 1'b0, 8'd7, 6, 8'd6);
      applyStimulus(cyc);
      dbg_addr = 8'd200;
      #1;
      checkOutput("dbg_out_of_range", 32'(dbg_data), 32'd0);

      checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
